// File: rtl/ksa.sv
// ksa: ARC4 key-scheduling engine.
// Permutes an identity S memory in place using a 24-bit key. It drives a
// single-port synchronous RAM with 1-cycle read latency. Each of the 256
// iterations takes six cycles:
//   read S[i], wait, read S[j], wait, write S[i], write S[j].
module ksa (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  addr,
    input  logic [7:0]  rddata,
    output logic [7:0]  wrdata,
    output logic        wren
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_I   = 3'd1,
        RD_I_W = 3'd2,
        RD_J   = 3'd3,
        RD_J_W = 3'd4,
        WR_I   = 3'd5,
        WR_J   = 3'd6
    } state_t;

    state_t      state, state_next;
    logic [7:0]  i, j, si, sj;
    logic [1:0]  k3;       // i mod 3, kept as a wrapping counter instead of a divider
    logic [7:0]  keybyte;
    logic [7:0]  j_next;

    // key byte for the current i; the first key byte is the most significant
    always_comb begin
        case (k3)
            2'd0:    keybyte = key[23:16];
            2'd1:    keybyte = key[15:8];
            default: keybyte = key[7:0];
        endcase
    end

    // carries are dropped, so j wraps modulo 256
    assign j_next = j + rddata + keybyte;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // next-state logic: a fixed six-step loop per index
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = RD_I;
            RD_I:    state_next = RD_I_W;
            RD_I_W:  state_next = RD_J;
            RD_J:    state_next = RD_J_W;
            RD_J_W:  state_next = WR_I;
            WR_I:    state_next = WR_J;
            WR_J:    state_next = (i == 8'hFF) ? IDLE : RD_I;
            default: state_next = IDLE;
        endcase
    end

    // datapath registers: indices, captured S values and the mod-3 counter
    always_ff @(posedge clk) begin
        if (rst) begin
            i  <= 8'd0;
            j  <= 8'd0;
            si <= 8'd0;
            sj <= 8'd0;
            k3 <= 2'd0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    i  <= 8'd0;
                    j  <= 8'd0;
                    k3 <= 2'd0;
                end
                RD_I_W: begin
                    si <= rddata;
                    j  <= j_next;
                end
                RD_J_W: sj <= rddata;
                WR_J: begin
                    i  <= i + 8'd1;
                    k3 <= (k3 == 2'd2) ? 2'd0 : k3 + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs. rddata never reaches the RAM bus combinationally.
    // When i == j, both writes hit the same address with the same value.
    always_comb begin
        rdy    = 1'b0;
        addr   = 8'd0;
        wrdata = 8'd0;
        wren   = 1'b0;
        case (state)
            IDLE:          rdy = 1'b1;
            RD_I, RD_I_W:  addr = i;
            RD_J, RD_J_W:  addr = j;
            WR_I: begin
                addr   = i;
                wrdata = sj;
                wren   = 1'b1;
            end
            WR_J: begin
                addr   = j;
                wrdata = si;
                wren   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
